// File: rtl/mem_pkg.sv
// mem_pkg: shared unit-select codes, address fields and FSM state for the memory-mapped units.
package mem_pkg;
  typedef enum logic [3:0] {
    MainMemEn    = 4'd0,
    RegisterEn   = 4'd1,
    InstrMemEn   = 4'd2,
    MatrixAluEn  = 4'd3,
    IntegerAluEn = 4'd4,
    ExecuteEn    = 4'd5
  } unit_e;
  localparam int SEL_MSB = 15;
  localparam int SEL_LSB = 12;
  localparam int IDX_W   = 12;
  localparam int LANE_W  = 32;
  typedef enum logic {CLEAR, READY} state_e;
endpackage

// File: rtl/mem_read_pipe.sv
// mem_read_pipe: LAT-deep valid+data shift register; output data holds between valid pulses.
module mem_read_pipe #(
  parameter int W   = 256,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  logic [LAT-1:0] v;
  logic [W-1:0]   d [LAT];
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < LAT; i++) d[i] <= '0;
    end else begin
      v <= LAT'({v, in_valid});
      if (in_valid) d[0] <= in_data;
      for (int i = 1; i < LAT; i++) if (v[i-1]) d[i] <= d[i-1];
    end
  end
  assign out_valid = v[LAT-1];
  assign out_data  = d[LAT-1];
endmodule

// File: rtl/main_memory_ctrl.sv
// main_memory_ctrl: cleared-on-reset main memory with pipelined reads and range checking.
// Optional MAIN_MEM_LANE_MASK_EN adds the LaneMask port for per-32-bit-lane writes.
module main_memory_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W   = 256,
  parameter int DEPTH    = 4,
  parameter int SEL_ID   = int'(MainMemEn),
  parameter int READ_LAT = 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [15:0]              address,
  input  logic                     nRead,
  input  logic                     nWrite,
  input  logic [DATA_W-1:0]        ExecDataOut,
`ifdef MAIN_MEM_LANE_MASK_EN
  input  logic [DATA_W/LANE_W-1:0] LaneMask,
`endif
  output logic [DATA_W-1:0]        MemDataOut,
  output logic                     MemValid,
  output logic                     Busy,
  output logic                     AddrErr
);
  localparam int LANES = DATA_W / LANE_W;
  localparam int AW    = DEPTH > 1 ? $clog2(DEPTH) : 1;
  state_e            state;
  logic [AW-1:0]     cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic [AW-1:0]     a;
  logic              acc, rd, wr, in_range;
  logic [DATA_W-1:0] rdata, wbits;
  logic [LANES-1:0]  lanes;
  assign idx      = address[IDX_W-1:0];
  assign a        = idx[AW-1:0];
  assign in_range = {1'b0, idx} < (IDX_W+1)'(DEPTH);
  assign acc      = !Busy && address[SEL_MSB:SEL_LSB] == 4'(SEL_ID);
  assign rd       = acc && !nRead;
  assign wr       = acc && !nWrite;
  assign rdata    = in_range ? mem[a] : '0;
`ifdef MAIN_MEM_LANE_MASK_EN
  assign lanes = LaneMask;
`else
  assign lanes = '1;
`endif
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign wbits[l*LANE_W +: LANE_W] = {LANE_W{lanes[l]}};
  end
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (state == CLEAR) mem[cnt] <= '0;
      else if (wr && in_range) mem[a] <= (mem[a] & ~wbits) | (ExecDataOut & wbits);
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= CLEAR;
      cnt     <= '0;
      Busy    <= 1'b1;
      AddrErr <= 1'b0;
    end else begin
      AddrErr <= (rd || wr) && !in_range;
      if (state == CLEAR) begin
        cnt <= cnt + 1'b1;
        if (cnt == AW'(DEPTH - 1)) begin
          state <= READY;
          Busy  <= 1'b0;
        end
      end
    end
  end
  mem_read_pipe #(.W(DATA_W), .LAT(READ_LAT)) u_pipe (
    .clk      (Clk),
    .rst      (Reset),
    .in_valid (rd),
    .in_data  (rdata),
    .out_valid(MemValid),
    .out_data (MemDataOut)
  );
endmodule

// File: tb/tb_main_memory_ctrl.sv
// tb_main_memory_ctrl: directed and random stimulus against a queue-based behavioural model.
module tb_main_memory_ctrl;
  localparam int DW = 64, DEPTH = 4, RL = 3;
  logic          Clk = 0, Reset = 1, nRead = 1, nWrite = 1;
  logic [15:0]   address = 0;
  logic [DW-1:0] ExecDataOut = 0, MemDataOut;
  logic [1:0]    lm = 0;
  logic          MemValid, Busy, AddrErr;
  int            n_cmp = 0, n_bad = 0;

  main_memory_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .SEL_ID(0), .READ_LAT(RL)) dut (
    .Clk(Clk), .Reset(Reset), .address(address), .nRead(nRead), .nWrite(nWrite),
    .ExecDataOut(ExecDataOut),
`ifdef MAIN_MEM_LANE_MASK_EN
    .LaneMask(lm),
`endif
    .MemDataOut(MemDataOut), .MemValid(MemValid), .Busy(Busy), .AddrErr(AddrErr)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  typedef struct { int due; logic [DW-1:0] d; } rd_t;
  rd_t           q[$];
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] e_data = 0;
  logic          e_valid = 0, e_err = 0, started = 0;
  int            bcnt = DEPTH, cyc = 0;

  always @(posedge Clk) begin
    int idx;
    bit acc;
    logic [1:0] mk;
    cyc++;
    if (Reset) begin
      bcnt = DEPTH; q.delete(); e_valid = 0; e_data = 0; e_err = 0; started = 1;
    end else begin
      idx = int'(address[11:0]);
      acc = bcnt == 0 && address[15:12] == 4'd0 && (!nRead || !nWrite);
      e_err = acc && idx >= DEPTH;
      if (acc && !nRead) q.push_back('{cyc + RL - 1, idx < DEPTH ? m_mem[idx] : '0});
`ifdef MAIN_MEM_LANE_MASK_EN
      mk = lm;
`else
      mk = 2'b11;
`endif
      if (acc && !nWrite && idx < DEPTH)
        for (int l = 0; l < 2; l++) if (mk[l]) m_mem[idx][l*32 +: 32] = ExecDataOut[l*32 +: 32];
      if (bcnt > 0) begin m_mem[DEPTH - bcnt] = '0; bcnt--; end
      e_valid = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        e_valid = 1; e_data = q[0].d; void'(q.pop_front());
      end
    end
  end

  always @(negedge Clk) if (started) begin
    check("busy", Busy, bcnt > 0);
    check("valid", MemValid, e_valid);
    check("data", MemDataOut, e_data);
    check("addr_err", AddrErr, e_err);
  end

  task automatic step(input bit r, input bit w, input logic [15:0] a, input logic [DW-1:0] d,
                      input logic [1:0] m, input bit rst = 0);
    @(negedge Clk);
    Reset = rst; nRead = !r; nWrite = !w; address = a; ExecDataOut = d; lm = m;
  endtask

  task automatic idle();
    step(0, 0, 16'h0000, '0, 2'b00);
  endtask

  task automatic read_lit(input string nm, input logic [15:0] a, input logic [DW-1:0] exp);
    step(1, 0, a, '0, 2'b00);
    idle();
    idle();
    check({nm, "_early"}, MemValid, 1'b0);
    @(negedge Clk);
    check({nm, "_valid"}, MemValid, 1'b1);
    check({nm, "_data"}, MemDataOut, exp);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 50 && Busy; i++) @(negedge Clk);
    check("ready_timeout", Busy, 1'b0);
  endtask

  initial begin
    int busy_cycles;
    repeat (2) @(negedge Clk);
    check("reset_valid", MemValid, 1'b0);
    check("reset_data", MemDataOut, '0);
    Reset = 0;
    busy_cycles = 0;
    while (Busy && busy_cycles < 20) begin busy_cycles++; @(negedge Clk); end
    check("busy_cycles", busy_cycles, 4);
    for (int i = 0; i < 4; i++) read_lit("clear", 16'(i), '0);
    step(0, 1, 16'h0002, 64'hA5A5, 2'b11);
    read_lit("a5a5", 16'h0002, 64'hA5A5);
    step(0, 1, 16'h0000, 64'h77, 2'b11);
    step(0, 1, 16'h0001, 64'h11, 2'b11);
    step(1, 0, 16'h0000, '0, 2'b00);
    step(1, 0, 16'h0001, '0, 2'b00);
    step(1, 0, 16'h0002, '0, 2'b00);
    idle();
    check("b2b_0", MemDataOut, 64'h77);
    @(negedge Clk);
    check("b2b_1", MemDataOut, 64'h11);
    @(negedge Clk);
    check("b2b_2", MemDataOut, 64'hA5A5);
    step(1, 1, 16'h0001, 64'h22, 2'b11);
    idle();
    idle();
    @(negedge Clk);
    check("rw_old", MemDataOut, 64'h11);
    read_lit("rw_new", 16'h0001, 64'h22);
    step(0, 1, 16'h0007, 64'hFF, 2'b11);
    idle();
    check("oor_werr", AddrErr, 1'b1);
    @(negedge Clk);
    check("oor_werr_pulse", AddrErr, 1'b0);
    read_lit("oor_read", 16'h0007, '0);
    read_lit("oor_alias", 16'h0003, '0);
    step(1, 1, 16'h3001, 64'h99, 2'b11);
    idle();
    check("other_err", AddrErr, 1'b0);
    repeat (3) @(negedge Clk);
    check("other_valid", MemValid, 1'b0);
    read_lit("other_nowrite", 16'h0001, 64'h22);
`ifdef MAIN_MEM_LANE_MASK_EN
    step(0, 1, 16'h0003, '1, 2'b11);
    step(0, 1, 16'h0003, '0, 2'b01);
    read_lit("lane", 16'h0003, 64'hFFFFFFFF_00000000);
`endif
    step(1, 0, 16'h0000, '0, 2'b00);
    step(1, 0, 16'h0001, '0, 2'b00);
    step(0, 0, 16'h0000, '0, 2'b00, 1);
    step(0, 0, 16'h0000, '0, 2'b00, 0);
    check("flush_busy", Busy, 1'b1);
    check("flush_valid", MemValid, 1'b0);
    wait_ready();
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] a;
      a = {($urandom_range(0, 7) == 0) ? 4'd3 : 4'd0, 9'd0, 3'($urandom_range(0, 7))};
      if ($urandom_range(0, 199) == 0) step(0, 0, a, '0, 2'b00, 1);
      else step($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4, a,
                {$urandom, $urandom}, 2'($urandom));
    end
    idle();
    repeat (RL + 2) @(negedge Clk);
    check("queue_drained", 64'(q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/main_memory_ctrl.md
Name: main_memory_ctrl

Overview:
Parametrised successor of the single-cycle main memory unit: DEPTH words of DATA_W bits, selected by the top nibble of the shared 16-bit address bus.
- Adds a hardware clear sequencer after reset with a Busy indication.
- Adds a configurable read-latency pipeline with a MemValid strobe.
- Adds out-of-range detection.
- Sits on the same address/data buses as the register file, instruction memory, ALUs and execute unit.

Parameters:
DATA_W, 256, word width in bits (multiple of 32)
DEPTH, 4, number of words (1..4096)
SEL_ID, 0, unit select value matched against address[15:12] (MainMemEn)
READ_LAT, 1, cycles from accepted read to MemValid (1..4)

Ports:
Clk  input  1  clock, all logic on posedge
Reset  input  1  synchronous, active-high reset
address  input  16  [15:12] unit select, [11:0] word index
nRead  input  1  active-low read strobe
nWrite  input  1  active-low write strobe
ExecDataOut  input  DATA_W  write data
LaneMask  input  DATA_W/32  per-32-bit-lane write enable (MAIN_MEM_LANE_MASK_EN only)
MemDataOut  output  DATA_W  read data
MemValid  output  1  one-cycle pulse: MemDataOut carries a new read result
Busy  output  1  clear sequencer active; requests ignored
AddrErr  output  1  one-cycle pulse: accepted access had index >= DEPTH

Behaviour:
- Reset is synchronous and active-high on Clk; no asynchronous reset path.
- Reset values: MemDataOut=0, MemValid=0, AddrErr=0, Busy=1, FSM=CLEAR, clear counter=0, read pipeline flushed.
- FSM CLEAR:
  - Each cycle writes 0 to word[counter], then counter++.
  - After the cycle that writes word DEPTH-1, go to READY; Busy falls the following cycle.
  - The full clear takes exactly DEPTH cycles after Reset deasserts.
- FSM READY: Busy=0. Stays here until Reset.
- Accept condition: Busy=0 and address[15:12]==SEL_ID. Strobes are ignored otherwise; no MemValid, no AddrErr.
- Write: nWrite=0 and accepted -> word[address[11:0]] <= ExecDataOut at this posedge.
- Read: nRead=0 and accepted -> captures word[address[11:0]].
  - Result appears on MemDataOut with MemValid=1 exactly READ_LAT cycles later.
  - Pipelined: one read per cycle sustained, results in order.
- Read and write in the same cycle, same index: the read returns the pre-write (old) data; the write still takes effect.
- Index >= DEPTH:
  - Write is dropped and memory is unchanged.
  - Read returns all-zero data with MemValid at normal latency.
  - AddrErr pulses one cycle, aligned with the acceptance cycle +1 for both reads and writes.
- MemDataOut holds its last value while MemValid=0.
- Both strobes high: no action.
- Reset mid-operation (during CLEAR or with reads in flight):
  - In-flight reads are discarded; no MemValid for them.
  - FSM returns to CLEAR and the counter restarts at 0.
- Index arithmetic: only the low clog2(DEPTH) bits address storage, but the range check uses all 12 index bits.

Optional Feature:
MAIN_MEM_LANE_MASK_EN:
- Defined: LaneMask port exists. An accepted write updates only 32-bit lanes i with LaneMask[i]=1; other lanes keep their old contents. LaneMask=0 makes the write a no-op, but AddrErr still applies.
- Undefined: port absent; every write updates the full word.

Decomposition:
- Shared package mem_pkg holds:
  - unit select enum (MainMemEn=0, RegisterEn=1, InstrMemEn=2, MatrixAluEn=3, IntegerAluEn=4, ExecuteEn=5)
  - address field constants (SEL_MSB=15, SEL_LSB=12, IDX_W=12)
  - lane width constant 32
  - FSM state typedef {CLEAR, READY}
- One sub-module, mem_read_pipe: a READ_LAT-deep valid+data shift register with synchronous flush on Reset.

Test Plan:
- Reset for 2 cycles, DEPTH=4 -> Busy=1 for exactly 4 cycles after release, then 0; reads of indices 0..3 all return 0.
- Write 0xA5A5 (zero-extended) to address 0x0002, then read 0x0002 with READ_LAT=3 -> MemValid pulses exactly 3 cycles after the read, MemDataOut=0xA5A5.
- Back-to-back reads of 0x0000, 0x0001, 0x0002 over three cycles -> three consecutive MemValid pulses carrying data in order.
- Same-cycle read+write at 0x0001 (old=0x11, new=0x22) -> read returns 0x11; a subsequent read returns 0x22.
- Access 0x0007 with DEPTH=4, and access 0x3001 -> for 0x0007: AddrErr pulses, the read returns 0, and memory is unchanged. For 0x3001 (other unit): no MemValid, no AddrErr.
- Reset asserted with 2 reads in flight -> no MemValid for either, Busy=1, clear restarts. With MAIN_MEM_LANE_MASK_EN, a write with LaneMask=0x01 changes only bits [31:0].
